line_cmd_scheduler: RTL and testbench
=====================================

// Module: line_cmd_scheduler
// PURPOSE
//  Shares one Bresenham line engine between P_NUM_REQ line-command requesters using round-robin
//  arbitration. Latches the winning command, loads the engine and forwards each rasterised pixel,
//  tagged with colour and source ID, to the pixel sink. Pulses a per-requester done when the line completes.
//  Sits between the command sources (blitter, overlay, GUI) and the framebuffer write path.
// PARAMETERS
//  P_NUM_REQ    4   number of requesters (2..8)
//  P_X_COORD_W  11  x coordinate width; must match the engine
//  P_Y_COORD_W  11  y coordinate width; must match the engine
//  P_COLOR_W    8   pixel colour width
// PORTS
//  i_clk         in   1               clock
//  i_reset       in   1               synchronous, active-high reset
//  i_req         in   N               per-requester command valid; held with its data until granted
//  i_req_x0/x1   in   N*P_X_COORD_W   flattened endpoints; requester k occupies slice k
//  i_req_y0/y1   in   N*P_Y_COORD_W   flattened endpoints
//  i_req_color   in   N*P_COLOR_W     flattened colour
//  o_gnt         out  N               one-hot, one-cycle pulse: command accepted
//  o_eng_x0/x1   out  P_X_COORD_W     engine endpoints; stable from LOAD until the next grant
//  o_eng_y0/y1   out  P_Y_COORD_W     engine endpoints
//  o_eng_load    out  1               engine load strobe
//  i_eng_x_val   in   P_X_COORD_W     engine pixel x
//  i_eng_y_val   in   P_Y_COORD_W     engine pixel y
//  i_eng_vals_rdy in  1               engine pixel valid
//  i_eng_waiting in   1               engine idle
//  o_pix_valid   out  1               pixel strobe; the sink must accept every cycle (no backpressure)
//  o_pix_x/o_pix_y out X/Y width      pixel coordinates
//  o_pix_color   out  P_COLOR_W       colour of the active command
//  o_pix_src     out  clog2(N)        ID of the requester that owns the pixel
//  o_pix_last    out  1               final pixel of the line
//  o_done        out  N               one-hot pulse, coincident with o_pix_last
//  o_busy        out  1               high in every state except ARB
// BEHAVIOUR
//  - Reset: state=ARB, RR pointer=N-1 (so requester 0 has priority first).
//    All outputs 0: o_gnt, o_eng_*, o_pix_*, o_done, o_busy.
//    The engine shares i_reset, so a reset mid-line abandons the line; no o_done is issued.
//  - FSM ARB -> LOAD -> START -> DRAW -> ARB.
//    ARB: when |i_req and i_eng_waiting:
//      * the RR winner is the first requester after the pointer;
//      * latch its coords, colour and ID; pulse o_gnt[win] next cycle; pointer <= win; go to LOAD.
//    LOAD: o_eng_load=1 for exactly one cycle; go to START.
//    START: wait for i_eng_waiting==0, then go to DRAW. Pixels are ignored in this state.
//    DRAW: for each i_eng_vals_rdy, register the pixel outputs (1-cycle latency), o_pix_valid=1.
//      When i_eng_waiting rises, that same cycle's vals_rdy is the final pixel:
//      set o_pix_last=1 and o_done[src]=1, then go to ARB.
//  - i_eng_vals_rdy is ignored outside DRAW; the engine's vals_rdy is not reset.
//  - Minimum gap between lines is 1 ARB cycle.
//  - Requests arriving or dropped mid-line are not sampled until ARB.
//  - Dropping i_req before grant is legal; that request is lost.
//  - Pixel count per line = max(|dx|,|dy|)+1. A zero-length line gives 1 pixel with last=1.
//  - No arithmetic on coordinates; widths pass straight through.
// STRUCTURE
//  - Package line_pkg:
//    * sched_state_t {ARB, LOAD, START, DRAW};
//    * coordinate/colour width localparams;
//    * a slice-select function for the flattened buses.
//  - Sub-module rr_arbiter: N-wide request vector and pointer in, one-hot grant and binary index out.
//    Purely combinational; the pointer register lives in line_cmd_scheduler.
// TESTING
//  - Single req0 (0,0)->(3,1), colour 0x5A:
//    o_gnt=0001; pixels (0,0),(1,0),(2,1),(3,1), src=0; last and o_done[0] on (3,1).
//  - All 4 requests held high: grants in order 0,1,2,3,0.
//    Each o_done precedes the next o_gnt; there is no pixel interleaving between sources.
//  - Steep line req2 (5,0)->(6,4): 5 pixels, monotonic in y, src=2, one o_done[2].
//  - Zero-length req1 (7,7)->(7,7): exactly one pixel (7,7) with o_pix_last=1.
//  - i_reset during DRAW after 2 pixels:
//    all outputs 0 next cycle, no o_done; the next request is served normally from (x0,y0).
//  - req3 rising mid-line for req0: o_gnt[3] only after o_done[0] plus 1 ARB cycle.
//    Spurious i_eng_vals_rdy injected in ARB produces no o_pix_valid.

Source files
------------

// File: rtl/line_cmd_scheduler_pkg.sv
// Shared types and widths for the line command scheduler slice.
// Latency: none (types, constants and a pure helper function only).
// Backpressure: not applicable.
package line_pkg;

    localparam int LP_X_COORD_W = 11;
    localparam int LP_Y_COORD_W = 11;
    localparam int LP_COLOR_W   = 8;

    // Scheduler walks ARB -> LOAD -> START -> DRAW -> ARB
    typedef enum logic [1:0] {
        ARB   = 2'd0,
        LOAD  = 2'd1,
        START = 2'd2,
        DRAW  = 2'd3
    } sched_state_t;

    // Low bit of requester idx's field inside a flattened bus of width-bit fields
    function automatic int slice_lo(input int idx, input int width);
        return idx * width;
    endfunction

endpackage

// File: rtl/line_cmd_scheduler_if.sv
// Bundles requester, engine and pixel-sink signals of the line command scheduler.
// Latency: wires only.
// Backpressure: requests held until o_gnt; pixel sink has none.
interface line_cmd_scheduler_if
    import line_pkg::*;
#(
    parameter int P_NUM_REQ   = 4,
    parameter int P_X_COORD_W = LP_X_COORD_W,
    parameter int P_Y_COORD_W = LP_Y_COORD_W,
    parameter int P_COLOR_W   = LP_COLOR_W
);
    localparam int LP_SRC_W = $clog2(P_NUM_REQ);

    // requester side
    logic [P_NUM_REQ-1:0]             i_req;
    logic [P_NUM_REQ*P_X_COORD_W-1:0] i_req_x0;
    logic [P_NUM_REQ*P_X_COORD_W-1:0] i_req_x1;
    logic [P_NUM_REQ*P_Y_COORD_W-1:0] i_req_y0;
    logic [P_NUM_REQ*P_Y_COORD_W-1:0] i_req_y1;
    logic [P_NUM_REQ*P_COLOR_W-1:0]   i_req_color;
    logic [P_NUM_REQ-1:0]             o_gnt;
    logic [P_NUM_REQ-1:0]             o_done;
    logic                             o_busy;

    // engine side
    logic [P_X_COORD_W-1:0]           o_eng_x0;
    logic [P_X_COORD_W-1:0]           o_eng_x1;
    logic [P_Y_COORD_W-1:0]           o_eng_y0;
    logic [P_Y_COORD_W-1:0]           o_eng_y1;
    logic                             o_eng_load;
    logic [P_X_COORD_W-1:0]           i_eng_x_val;
    logic [P_Y_COORD_W-1:0]           i_eng_y_val;
    logic                             i_eng_vals_rdy;
    logic                             i_eng_waiting;

    // pixel sink side
    logic                             o_pix_valid;
    logic [P_X_COORD_W-1:0]           o_pix_x;
    logic [P_Y_COORD_W-1:0]           o_pix_y;
    logic [P_COLOR_W-1:0]             o_pix_color;
    logic [LP_SRC_W-1:0]              o_pix_src;
    logic                             o_pix_last;

    modport slave (
        input  i_req, i_req_x0, i_req_x1, i_req_y0, i_req_y1, i_req_color,
        input  i_eng_x_val, i_eng_y_val, i_eng_vals_rdy, i_eng_waiting,
        output o_gnt, o_done, o_busy,
        output o_eng_x0, o_eng_x1, o_eng_y0, o_eng_y1, o_eng_load,
        output o_pix_valid, o_pix_x, o_pix_y, o_pix_color, o_pix_src, o_pix_last
    );

    modport master (
        output i_req, i_req_x0, i_req_x1, i_req_y0, i_req_y1, i_req_color,
        output i_eng_x_val, i_eng_y_val, i_eng_vals_rdy, i_eng_waiting,
        input  o_gnt, o_done, o_busy,
        input  o_eng_x0, o_eng_x1, o_eng_y0, o_eng_y1, o_eng_load,
        input  o_pix_valid, o_pix_x, o_pix_y, o_pix_color, o_pix_src, o_pix_last
    );

endinterface

// File: rtl/line_cmd_scheduler_rr_arbiter.sv
// Round-robin pick: first active request strictly after the pointer, wrapping.
// Latency: combinational.
// Backpressure: none; caller decides when the grant is taken.
module rr_arbiter #(
    parameter  int P_NUM_REQ = 4,
    localparam int LP_IDX_W  = $clog2(P_NUM_REQ)
) (
    input  logic [P_NUM_REQ-1:0] i_req,
    input  logic [LP_IDX_W-1:0]  i_ptr,
    output logic [P_NUM_REQ-1:0] o_gnt,
    output logic [LP_IDX_W-1:0]  o_idx,
    output logic                 o_any
);

    // Lowest request overall is the wrap-around fallback; lowest above the pointer overrides it
    always_comb begin
        o_idx = '0;
        o_gnt = '0;
        o_any = |i_req;
        for (int j = P_NUM_REQ - 1; j >= 0; j--) begin
            if (i_req[j]) begin
                o_idx = LP_IDX_W'(j);
            end
        end
        for (int j = P_NUM_REQ - 1; j >= 0; j--) begin
            if (i_req[j] && (j > int'(i_ptr))) begin
                o_idx = LP_IDX_W'(j);
            end
        end
        for (int j = 0; j < P_NUM_REQ; j++) begin
            o_gnt[j] = o_any && (o_idx == LP_IDX_W'(j));
        end
    end

endmodule

// File: rtl/line_cmd_scheduler.sv
// Shares one Bresenham engine among requesters round-robin; tags pixels with colour/source.
// Latency: o_gnt/o_eng_load 1 cycle after ARB accepts; pixels 1 cycle after engine strobe.
// Backpressure: requesters hold i_req until o_gnt; pixel sink must accept every cycle.
module line_cmd_scheduler
    import line_pkg::*;
#(
    parameter int P_NUM_REQ   = 4,
    parameter int P_X_COORD_W = LP_X_COORD_W,
    parameter int P_Y_COORD_W = LP_Y_COORD_W,
    parameter int P_COLOR_W   = LP_COLOR_W
) (
    input  logic                i_clk,
    input  logic                i_reset,
    line_cmd_scheduler_if.slave bus
);

    localparam int LP_SRC_W = $clog2(P_NUM_REQ);

    sched_state_t           state_q, state_d;
    logic [LP_SRC_W-1:0]    ptr_q, ptr_d;
    logic [LP_SRC_W-1:0]    src_q, src_d;
    logic [P_COLOR_W-1:0]   color_q, color_d;
    logic [P_NUM_REQ-1:0]   gnt_q, gnt_d;
    logic [P_X_COORD_W-1:0] eng_x0_q, eng_x0_d, eng_x1_q, eng_x1_d;
    logic [P_Y_COORD_W-1:0] eng_y0_q, eng_y0_d, eng_y1_q, eng_y1_d;
    logic                   eng_load_q, eng_load_d;
    logic                   pix_valid_q, pix_valid_d;
    logic [P_X_COORD_W-1:0] pix_x_q, pix_x_d;
    logic [P_Y_COORD_W-1:0] pix_y_q, pix_y_d;
    logic [P_COLOR_W-1:0]   pix_color_q, pix_color_d;
    logic [LP_SRC_W-1:0]    pix_src_q, pix_src_d;
    logic                   pix_last_q, pix_last_d;
    logic [P_NUM_REQ-1:0]   done_q, done_d;

    logic [P_NUM_REQ-1:0]   arb_gnt;
    logic [LP_SRC_W-1:0]    arb_idx;
    logic                   arb_any;
    logic [P_X_COORD_W-1:0] win_x0, win_x1;
    logic [P_Y_COORD_W-1:0] win_y0, win_y1;
    logic [P_COLOR_W-1:0]   win_color;

    rr_arbiter #(
        .P_NUM_REQ (P_NUM_REQ)
    ) u_rr_arbiter (
        .i_req (bus.i_req),
        .i_ptr (ptr_q),
        .o_gnt (arb_gnt),
        .o_idx (arb_idx),
        .o_any (arb_any)
    );

    // Pull the winning requester's command fields out of the flattened buses
    always_comb begin
        win_x0    = '0;
        win_x1    = '0;
        win_y0    = '0;
        win_y1    = '0;
        win_color = '0;
        for (int k = 0; k < P_NUM_REQ; k++) begin
            if (arb_idx == LP_SRC_W'(k)) begin
                win_x0    = bus.i_req_x0[slice_lo(k, P_X_COORD_W) +: P_X_COORD_W];
                win_x1    = bus.i_req_x1[slice_lo(k, P_X_COORD_W) +: P_X_COORD_W];
                win_y0    = bus.i_req_y0[slice_lo(k, P_Y_COORD_W) +: P_Y_COORD_W];
                win_y1    = bus.i_req_y1[slice_lo(k, P_Y_COORD_W) +: P_Y_COORD_W];
                win_color = bus.i_req_color[slice_lo(k, P_COLOR_W) +: P_COLOR_W];
            end
        end
    end

    // Next-state: arbitration, engine handshake and pixel forwarding
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        src_d       = src_q;
        color_d     = color_q;
        eng_x0_d    = eng_x0_q;
        eng_x1_d    = eng_x1_q;
        eng_y0_d    = eng_y0_q;
        eng_y1_d    = eng_y1_q;
        pix_x_d     = pix_x_q;
        pix_y_d     = pix_y_q;
        pix_color_d = pix_color_q;
        pix_src_d   = pix_src_q;
        gnt_d       = '0;
        eng_load_d  = 1'b0;
        pix_valid_d = 1'b0;
        pix_last_d  = 1'b0;
        done_d      = '0;
        case (state_q)
            ARB: begin
                // Only start a line when the engine is idle, so one line never overlaps another
                if (arb_any && bus.i_eng_waiting) begin
                    eng_x0_d   = win_x0;
                    eng_x1_d   = win_x1;
                    eng_y0_d   = win_y0;
                    eng_y1_d   = win_y1;
                    color_d    = win_color;
                    src_d      = arb_idx;
                    ptr_d      = arb_idx;
                    gnt_d      = arb_gnt;
                    eng_load_d = 1'b1;
                    state_d    = LOAD;
                end
            end
            LOAD: begin
                state_d = START;
            end
            START: begin
                // Engine still reports idle until it has taken the load
                if (!bus.i_eng_waiting) begin
                    state_d = DRAW;
                end
            end
            DRAW: begin
                if (bus.i_eng_vals_rdy) begin
                    pix_valid_d = 1'b1;
                    pix_x_d     = bus.i_eng_x_val;
                    pix_y_d     = bus.i_eng_y_val;
                    pix_color_d = color_q;
                    pix_src_d   = src_q;
                end
                // Engine turning idle marks the pixel of this same cycle as the last one
                if (bus.i_eng_waiting) begin
                    pix_last_d = bus.i_eng_vals_rdy;
                    for (int k = 0; k < P_NUM_REQ; k++) begin
                        done_d[k] = (src_q == LP_SRC_W'(k));
                    end
                    state_d = ARB;
                end
            end
            default: begin
                state_d = ARB;
            end
        endcase
    end

    // State and output registers, synchronous reset
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q     <= ARB;
            ptr_q       <= LP_SRC_W'(P_NUM_REQ - 1);
            src_q       <= '0;
            color_q     <= '0;
            gnt_q       <= '0;
            eng_x0_q    <= '0;
            eng_x1_q    <= '0;
            eng_y0_q    <= '0;
            eng_y1_q    <= '0;
            eng_load_q  <= 1'b0;
            pix_valid_q <= 1'b0;
            pix_x_q     <= '0;
            pix_y_q     <= '0;
            pix_color_q <= '0;
            pix_src_q   <= '0;
            pix_last_q  <= 1'b0;
            done_q      <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            src_q       <= src_d;
            color_q     <= color_d;
            gnt_q       <= gnt_d;
            eng_x0_q    <= eng_x0_d;
            eng_x1_q    <= eng_x1_d;
            eng_y0_q    <= eng_y0_d;
            eng_y1_q    <= eng_y1_d;
            eng_load_q  <= eng_load_d;
            pix_valid_q <= pix_valid_d;
            pix_x_q     <= pix_x_d;
            pix_y_q     <= pix_y_d;
            pix_color_q <= pix_color_d;
            pix_src_q   <= pix_src_d;
            pix_last_q  <= pix_last_d;
            done_q      <= done_d;
        end
    end

    assign bus.o_gnt       = gnt_q;
    assign bus.o_eng_x0    = eng_x0_q;
    assign bus.o_eng_x1    = eng_x1_q;
    assign bus.o_eng_y0    = eng_y0_q;
    assign bus.o_eng_y1    = eng_y1_q;
    assign bus.o_eng_load  = eng_load_q;
    assign bus.o_pix_valid = pix_valid_q;
    assign bus.o_pix_x     = pix_x_q;
    assign bus.o_pix_y     = pix_y_q;
    assign bus.o_pix_color = pix_color_q;
    assign bus.o_pix_src   = pix_src_q;
    assign bus.o_pix_last  = pix_last_q;
    assign bus.o_done      = done_q;
    assign bus.o_busy      = (state_q != ARB);

endmodule

// File: tb/tb_line_cmd_scheduler.sv
// Directed bench for line_cmd_scheduler with a behavioural Bresenham engine.
// Latency: checks sampled on the falling edge.
// Backpressure: requesters drop i_req on o_gnt unless a test holds them.
module tb_line_cmd_scheduler;

    localparam int N  = 4;
    localparam int XW = 11;
    localparam int YW = 11;
    localparam int CW = 8;

    logic clk;
    logic rst;
    logic eng_vals_m;
    logic inject_vals;
    logic auto_drop;
    int   errors;
    int   checks;

    line_cmd_scheduler_if #(
        .P_NUM_REQ(N), .P_X_COORD_W(XW), .P_Y_COORD_W(YW), .P_COLOR_W(CW)
    ) bus ();

    line_cmd_scheduler #(
        .P_NUM_REQ(N), .P_X_COORD_W(XW), .P_Y_COORD_W(YW), .P_COLOR_W(CW)
    ) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign bus.i_eng_vals_rdy = eng_vals_m | inject_vals;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Behavioural engine: one idle cycle after load, then one pixel per cycle,
    // raising waiting together with the final pixel.
    initial begin : engine_model
        int  cx, cy, ex1, ey1, ddx, ddy, sx, sy, err, e2;
        bit  drawing;
        drawing           = 1'b0;
        bus.i_eng_waiting = 1'b1;
        eng_vals_m        = 1'b0;
        bus.i_eng_x_val   = '0;
        bus.i_eng_y_val   = '0;
        forever begin
            @(posedge clk);
            if (rst) begin
                drawing = 1'b0;
                #1;
                bus.i_eng_waiting = 1'b1;
                eng_vals_m        = 1'b0;
            end else if (!drawing && bus.o_eng_load) begin
                cx  = int'(bus.o_eng_x0);
                cy  = int'(bus.o_eng_y0);
                ex1 = int'(bus.o_eng_x1);
                ey1 = int'(bus.o_eng_y1);
                ddx = (ex1 > cx) ? ex1 - cx : cx - ex1;
                ddy = (ey1 > cy) ? cy - ey1 : ey1 - cy;
                sx  = (cx < ex1) ? 1 : -1;
                sy  = (cy < ey1) ? 1 : -1;
                err = ddx + ddy;
                drawing = 1'b1;
                #1;
                bus.i_eng_waiting = 1'b0;
                eng_vals_m        = 1'b0;
            end else if (drawing) begin
                #1;
                eng_vals_m      = 1'b1;
                bus.i_eng_x_val = XW'(cx);
                bus.i_eng_y_val = YW'(cy);
                if (cx == ex1 && cy == ey1) begin
                    bus.i_eng_waiting = 1'b1;
                    drawing = 1'b0;
                end else begin
                    bus.i_eng_waiting = 1'b0;
                    e2 = 2 * err;
                    if (e2 >= ddy) begin err = err + ddy; cx = cx + sx; end
                    if (e2 <= ddx) begin err = err + ddx; cy = cy + sy; end
                end
            end else begin
                #1;
                eng_vals_m = 1'b0;
            end
        end
    end

    task automatic set_cmd(input int k, input int x0, input int y0, input int x1, input int y1, input int col);
        bus.i_req_x0[k*XW +: XW]    = XW'(x0);
        bus.i_req_y0[k*YW +: YW]    = YW'(y0);
        bus.i_req_x1[k*XW +: XW]    = XW'(x1);
        bus.i_req_y1[k*YW +: YW]    = YW'(y1);
        bus.i_req_color[k*CW +: CW] = CW'(col);
    endtask

    // Follow one line from grant to final pixel, checking every output along the way
    task automatic run_line(input int src, input int n, input int ex[8], input int ey[8],
                            input int col, input logic [N-1:0] raise_mask, output int gnt_cyc);
        int idx, cyc;
        bit gseen;
        idx = 0; cyc = 0; gseen = 1'b0; gnt_cyc = -1;
        while (idx < n && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (bus.o_gnt != '0) begin
                chk("gnt_onehot", bus.o_gnt, 32'(1 << src));
                chk("gnt_once", gseen, 0);
                chk("eng_load_with_gnt", bus.o_eng_load, 1);
                chk("eng_x0", bus.o_eng_x0, ex[0]);
                chk("eng_y0", bus.o_eng_y0, ey[0]);
                chk("eng_x1", bus.o_eng_x1, ex[n-1]);
                chk("eng_y1", bus.o_eng_y1, ey[n-1]);
                gseen = 1'b1;
                gnt_cyc = cyc;
                if (auto_drop) bus.i_req = bus.i_req & ~bus.o_gnt;
            end
            if (bus.o_pix_valid) begin
                chk("pix_after_gnt", gseen, 1);
                chk("pix_x", bus.o_pix_x, ex[idx]);
                chk("pix_y", bus.o_pix_y, ey[idx]);
                chk("pix_color", bus.o_pix_color, col);
                chk("pix_src", bus.o_pix_src, src);
                chk("pix_last", bus.o_pix_last, (idx == n - 1) ? 1 : 0);
                chk("done_on_last", bus.o_done, (idx == n - 1) ? 32'(1 << src) : 0);
                if (idx == 0) bus.i_req = bus.i_req | raise_mask;
                idx++;
            end else begin
                chk("done_without_pix", bus.o_done, 0);
            end
        end
        chk("pix_count", idx, n);
    endtask

    initial begin : stim
        int ex[8];
        int ey[8];
        int gc;
        int cnt;
        int cyc;
        errors = 0; checks = 0;
        rst = 1'b1; inject_vals = 1'b0; auto_drop = 1'b1;
        bus.i_req = '0; bus.i_req_x0 = '0; bus.i_req_x1 = '0;
        bus.i_req_y0 = '0; bus.i_req_y1 = '0; bus.i_req_color = '0;
        repeat (3) @(negedge clk);

        // reset state
        chk("rst_gnt", bus.o_gnt, 0);
        chk("rst_load", bus.o_eng_load, 0);
        chk("rst_eng_x0", bus.o_eng_x0, 0);
        chk("rst_eng_y1", bus.o_eng_y1, 0);
        chk("rst_pix_valid", bus.o_pix_valid, 0);
        chk("rst_pix_x", bus.o_pix_x, 0);
        chk("rst_pix_last", bus.o_pix_last, 0);
        chk("rst_done", bus.o_done, 0);
        chk("rst_busy", bus.o_busy, 0);
        rst = 1'b0;

        // single requester 0: (0,0)->(3,1)
        set_cmd(0, 0, 0, 3, 1, 'h5A);
        bus.i_req[0] = 1'b1;
        ex = '{0, 1, 2, 3, 0, 0, 0, 0}; ey = '{0, 0, 1, 1, 0, 0, 0, 0};
        run_line(0, 4, ex, ey, 'h5A, '0, gc);
        chk("idle_after_line", bus.o_busy, 0);

        // all four held: order 0,1,2,3,0 from a fresh pointer
        rst = 1'b1; @(negedge clk); rst = 1'b0;
        set_cmd(1, 7, 7, 7, 7, 'h11);
        set_cmd(2, 5, 0, 6, 4, 'h22);
        set_cmd(3, 2, 3, 0, 3, 'h33);
        auto_drop = 1'b0;
        bus.i_req = 4'b1111;
        ex = '{0, 1, 2, 3, 0, 0, 0, 0}; ey = '{0, 0, 1, 1, 0, 0, 0, 0};
        run_line(0, 4, ex, ey, 'h5A, '0, gc);
        chk("rr_gap_1", gc, 1);
        ex = '{7, 0, 0, 0, 0, 0, 0, 0}; ey = '{7, 0, 0, 0, 0, 0, 0, 0};
        run_line(1, 1, ex, ey, 'h11, '0, gc);
        chk("rr_gap_2", gc, 1);
        ex = '{5, 5, 6, 6, 6, 0, 0, 0}; ey = '{0, 1, 2, 3, 4, 0, 0, 0};
        run_line(2, 5, ex, ey, 'h22, '0, gc);
        ex = '{2, 1, 0, 0, 0, 0, 0, 0}; ey = '{3, 3, 3, 0, 0, 0, 0, 0};
        run_line(3, 3, ex, ey, 'h33, '0, gc);
        ex = '{0, 1, 2, 3, 0, 0, 0, 0}; ey = '{0, 0, 1, 1, 0, 0, 0, 0};
        run_line(0, 4, ex, ey, 'h5A, '0, gc);
        bus.i_req = '0;
        auto_drop = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("no_gnt_when_idle", bus.o_gnt, 0);
        end

        // steep line from requester 2
        bus.i_req[2] = 1'b1;
        ex = '{5, 5, 6, 6, 6, 0, 0, 0}; ey = '{0, 1, 2, 3, 4, 0, 0, 0};
        run_line(2, 5, ex, ey, 'h22, '0, gc);

        // zero-length line from requester 1
        bus.i_req[1] = 1'b1;
        ex = '{7, 0, 0, 0, 0, 0, 0, 0}; ey = '{7, 0, 0, 0, 0, 0, 0, 0};
        run_line(1, 1, ex, ey, 'h11, '0, gc);

        // reset in DRAW after two pixels
        bus.i_req[0] = 1'b1;
        cnt = 0; cyc = 0;
        while (cnt < 2 && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (bus.o_gnt != '0) bus.i_req = bus.i_req & ~bus.o_gnt;
            if (bus.o_pix_valid) cnt++;
        end
        chk("pre_rst_pixels", cnt, 2);
        chk("pre_rst_busy", bus.o_busy, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_gnt", bus.o_gnt, 0);
        chk("mid_rst_load", bus.o_eng_load, 0);
        chk("mid_rst_eng_x1", bus.o_eng_x1, 0);
        chk("mid_rst_pix_valid", bus.o_pix_valid, 0);
        chk("mid_rst_pix_x", bus.o_pix_x, 0);
        chk("mid_rst_pix_color", bus.o_pix_color, 0);
        chk("mid_rst_pix_last", bus.o_pix_last, 0);
        chk("mid_rst_done", bus.o_done, 0);
        chk("mid_rst_busy", bus.o_busy, 0);
        rst = 1'b0;
        repeat (4) begin
            @(negedge clk);
            chk("post_rst_done", bus.o_done, 0);
            chk("post_rst_pix", bus.o_pix_valid, 0);
        end
        bus.i_req[0] = 1'b1;
        ex = '{0, 1, 2, 3, 0, 0, 0, 0}; ey = '{0, 0, 1, 1, 0, 0, 0, 0};
        run_line(0, 4, ex, ey, 'h5A, '0, gc);

        // requester 3 rises mid-line: served only after done plus one ARB cycle
        bus.i_req[0] = 1'b1;
        run_line(0, 4, ex, ey, 'h5A, 4'b1000, gc);
        ex = '{2, 1, 0, 0, 0, 0, 0, 0}; ey = '{3, 3, 3, 0, 0, 0, 0, 0};
        run_line(3, 3, ex, ey, 'h33, '0, gc);
        chk("late_req3_gnt_gap", gc, 1);

        // stray engine strobes while idle in ARB
        inject_vals = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("spurious_pix", bus.o_pix_valid, 0);
            chk("spurious_busy", bus.o_busy, 0);
        end
        inject_vals = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
